// File: rtl/muldiv_control_seq_if.sv
// Bundle between the MUL/DIV control sequencer and its surroundings: requests and IR/ALU
// status in, datapath strobes and sequencer status out.
// Handshake: start is a level request that is sampled only while the sequencer is idle or
// finishing (T6); done is high for exactly the T6 cycle, and illegal pulses for one cycle
// when an instruction is abandoned.
interface muldiv_control_seq_if #(
    parameter int BITS      = 64,
    parameter int REGISTERS = 16
);
    logic                 start;
    logic [BITS-1:0]      IRVal;
    logic                 alu_done;
    logic                 PCout, MARin, IncPC, RZin, Read, PCin, MDRin, IRin;
    logic                 MDRout, RYin, Zlowout, Zhighout, LOin, HIin, MUL, DIV;
    logic [REGISTERS-1:0] GPRout;
    logic                 busy, done, illegal;
    logic [2:0]           state_dbg;

    modport master (
        output start, IRVal, alu_done,
        input  PCout, MARin, IncPC, RZin, Read, PCin, MDRin, IRin,
        input  MDRout, RYin, Zlowout, Zhighout, LOin, HIin, MUL, DIV,
        input  GPRout, busy, done, illegal, state_dbg
    );

    modport slave (
        input  start, IRVal, alu_done,
        output PCout, MARin, IncPC, RZin, Read, PCin, MDRin, IRin,
        output MDRout, RYin, Zlowout, Zhighout, LOin, HIin, MUL, DIV,
        output GPRout, busy, done, illegal, state_dbg
    );
endinterface

// File: rtl/muldiv_control_seq.sv
// Hardwired T0-T6 fetch + MUL/DIV control sequencer for the bus datapath; T4 stretches until alu_done.
// Optional T4 watchdog: define MULDIV_WATCHDOG_EN to abort after MAX_WAIT cycles without alu_done.
module muldiv_control_seq #(
    parameter int         BITS      = 64,
    parameter int         REGISTERS = 16,
    parameter logic [4:0] OP_MUL    = 5'b01110,
    parameter logic [4:0] OP_DIV    = 5'b01111,
    parameter int         MAX_WAIT  = 64
) (
    input logic                 Clock,
    input logic                 reset,
    muldiv_control_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

    state_t     state_q, state_d;
    logic [4:0] opcode;
    logic [3:0] ra, rb;
    logic       is_mul, is_div, wd_abort;

    assign opcode = bus.IRVal[31:27];
    assign ra     = bus.IRVal[26:23];
    assign rb     = bus.IRVal[22:19];
    assign is_mul = (opcode == OP_MUL);
    assign is_div = (opcode == OP_DIV);

    // Indices beyond the register file select nothing rather than wrapping.
    function automatic logic [REGISTERS-1:0] gpr_sel(input logic [3:0] idx);
        logic [REGISTERS-1:0] v;
        v = '0;
        for (int i = 0; i < REGISTERS; i++) v[i] = (int'(idx) == i);
        return v;
    endfunction

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

`ifdef MULDIV_WATCHDOG_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_q;

    // Held at zero outside T4, so it reads 0 on the first T4 cycle and n-1 on the n-th.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset)              wait_q <= '0;
        else if (state_q == T4)  wait_q <= wait_q + WW'(1);
        else                     wait_q <= '0;
    end

    assign wd_abort = (state_q == T4) && !bus.alu_done && (wait_q == WW'(MAX_WAIT - 1));
`else
    logic unused_max_wait;
    assign unused_max_wait = |MAX_WAIT;
    assign wd_abort        = 1'b0;
`endif

    generate
        if (BITS > 32) begin : g_ir_hi
            logic unused_ir_hi;
            assign unused_ir_hi = ^bus.IRVal[BITS-1:32];
        end
    endgenerate

    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;

    always_comb begin
        state_d      = state_q;
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.RZin     = 1'b0;
        bus.Read     = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.MDRout   = 1'b0;
        bus.RYin     = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.LOin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.MUL      = 1'b0;
        bus.DIV      = 1'b0;
        bus.GPRout   = '0;
        bus.done     = 1'b0;
        bus.illegal  = 1'b0;
        case (state_q)
            IDLE: if (bus.start) state_d = T0;
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.RZin  = 1'b1;
                state_d   = T1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                state_d     = T2;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = T3;
            end
            T3: begin
                if (is_mul || is_div) begin
                    bus.GPRout = gpr_sel(ra);
                    bus.RYin   = 1'b1;
                    state_d    = T4;
                end else begin
                    bus.illegal = 1'b1;
                    state_d     = IDLE;
                end
            end
            T4: begin
                // A watchdog abort blanks every strobe for its cycle; alu_done on the limit cycle still wins.
                if (wd_abort) begin
                    bus.illegal = 1'b1;
                    state_d     = IDLE;
                end else begin
                    bus.GPRout = gpr_sel(rb);
                    bus.RZin   = 1'b1;
                    bus.MUL    = is_mul;
                    bus.DIV    = is_div;
                    if (bus.alu_done) state_d = T5;
                end
            end
            T5: begin
                bus.Zlowout = 1'b1;
                bus.LOin    = 1'b1;
                state_d     = T6;
            end
            T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.done     = 1'b1;
                state_d      = bus.start ? T0 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_muldiv_control_seq.sv
// Directed bench for muldiv_control_seq: a per-instruction output-trace model feeds an expected
// queue that one negedge compare process checks every cycle, plus literal pins and event counts.
module tb_muldiv_control_seq;
    localparam int BITS = 64;
    localparam int REGS = 16;
    localparam int MAXW = 8;
    localparam int W    = 35;   // {strobes[15:0], GPRout[15:0], busy, done, illegal}

    localparam logic [4:0] OPM = 5'b01110;
    localparam logic [4:0] OPD = 5'b01111;

    localparam logic [15:0] S_PCOUT = 16'h8000, S_MARIN = 16'h4000, S_INCPC  = 16'h2000;
    localparam logic [15:0] S_RZIN  = 16'h1000, S_READ  = 16'h0800, S_PCIN   = 16'h0400;
    localparam logic [15:0] S_MDRIN = 16'h0200, S_IRIN  = 16'h0100, S_MDROUT = 16'h0080;
    localparam logic [15:0] S_RYIN  = 16'h0040, S_ZLOW  = 16'h0020, S_ZHIGH  = 16'h0010;
    localparam logic [15:0] S_LOIN  = 16'h0008, S_HIIN  = 16'h0004, S_MUL    = 16'h0002;
    localparam logic [15:0] S_DIV   = 16'h0001;
    localparam logic [W-1:0] IDLE_V = '0;

    localparam logic [31:0] IR1 = 32'h7120_0000;   // MUL Ra=2 Rb=4
    localparam logic [31:0] IR2 = 32'h79A8_0000;   // DIV Ra=3 Rb=5
    localparam logic [31:0] IR3 = 32'h4A92_0000;   // opcode 9

    logic Clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0, done_cnt = 0, ill_cnt = 0, md_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] act, exp_v;

    muldiv_control_seq_if #(.BITS(BITS), .REGISTERS(REGS)) bus ();

    muldiv_control_seq #(
        .BITS(BITS), .REGISTERS(REGS), .OP_MUL(OPM), .OP_DIV(OPD), .MAX_WAIT(MAXW)
    ) dut (
        .Clock(Clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 Clock = ~Clock;

    assign act = {bus.PCout, bus.MARin, bus.IncPC, bus.RZin, bus.Read, bus.PCin, bus.MDRin,
                  bus.IRin, bus.MDRout, bus.RYin, bus.Zlowout, bus.Zhighout, bus.LOin, bus.HIin,
                  bus.MUL, bus.DIV, bus.GPRout, bus.busy, bus.done, bus.illegal};

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
        end
    endtask

    // ---------------- model ----------------
    function automatic logic [W-1:0] mk(input logic [15:0] s, input logic [15:0] g,
                                        input logic d, input logic il);
        return {s, g, 1'b1, d, il};
    endfunction

    function automatic bit legal_op(input logic [31:0] ir);
        return (ir[31:27] == OPM) || (ir[31:27] == OPD);
    endfunction

    // k = number of T4 cycles with alu_done low before it rises.
    function automatic bit aborts(input int k);
`ifdef MULDIV_WATCHDOG_EN
        return k >= MAXW;
`else
        return (k < 0);
`endif
    endfunction

    function automatic int model_len(input logic [31:0] ir, input int k);
        if (!legal_op(ir)) return 4;
        if (aborts(k))     return 4 + MAXW;
        return 7 + k;
    endfunction

    function automatic logic [W-1:0] model_at(input logic [31:0] ir, input int k, input int c);
        logic [15:0] ga, gb, op_s;
        int nt4;
        ga   = 16'(1) << ir[26:23];
        gb   = 16'(1) << ir[22:19];
        op_s = (ir[31:27] == OPM) ? S_MUL : S_DIV;
        nt4  = aborts(k) ? MAXW : k + 1;
        if (c == 0) return mk(S_PCOUT | S_MARIN | S_INCPC | S_RZIN, 16'h0, 1'b0, 1'b0);
        if (c == 1) return mk(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 1'b0, 1'b0);
        if (c == 2) return mk(S_MDROUT | S_IRIN, 16'h0, 1'b0, 1'b0);
        if (c == 3) return legal_op(ir) ? mk(S_RYIN, ga, 1'b0, 1'b0) : mk(16'h0, 16'h0, 1'b0, 1'b1);
        if (c < 4 + nt4) begin
            if (aborts(k) && c == 3 + nt4) return mk(16'h0, 16'h0, 1'b0, 1'b1);
            return mk(S_RZIN | op_s, gb, 1'b0, 1'b0);
        end
        if (c == 4 + nt4) return mk(S_ZLOW | S_LOIN, 16'h0, 1'b0, 1'b0);
        return mk(S_ZHIGH | S_HIIN, 16'h0, 1'b1, 1'b0);
    endfunction

    // ---------------- compare process ----------------
    always @(negedge Clock) begin
        if (!reset || exp_q.size() == 0) exp_v = IDLE_V;
        else                             exp_v = exp_q.pop_front();
        chk("cycle_outputs", {29'h0, act}, {29'h0, exp_v});
        if (bus.busy)            busy_cnt++;
        if (bus.done)            done_cnt++;
        if (bus.illegal)         ill_cnt++;
        if (bus.MUL || bus.DIV)  md_cnt++;
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        repeat (n) tick();
    endtask

    // Returns one cycle into T0.
    task automatic begin_start(input logic [31:0] ir);
        bus.IRVal = {$urandom, ir};
        bus.start = 1'b1;
        tick();
    endtask

    // Called during T0; drives one instruction and leaves start=hold on its final cycle.
    task automatic run_body(input logic [31:0] ir, input int k, input bit hold);
        int len;
        len = model_len(ir, k);
        for (int c = 0; c < len; c++) exp_q.push_back(model_at(ir, k, c));
        for (int c = 0; c < len; c++) begin
            bus.IRVal = (c < 3) ? {$urandom, $urandom} : {$urandom, ir};
            if (c >= 4 && c < 4 + k) bus.alu_done = 1'b0;
            else if (c == 4 + k)     bus.alu_done = 1'b1;
            else                     bus.alu_done = 1'($urandom_range(0, 1));
            bus.start = (c == len - 1) ? hold : 1'($urandom_range(0, 1));
            tick();
        end
        bus.start = 1'b0;
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        return {op, a, b, 19'h0};
    endfunction

    initial begin
        int b0, d0, i0, m0;
        bus.start    = 1'b0;
        bus.IRVal    = '0;
        bus.alu_done = 1'b0;
        repeat (2) tick();
        chk("reset_outputs", {29'h0, act}, 64'h0);
        chk("reset_state", {61'h0, bus.state_dbg}, 64'h0);
        reset = 1'b1;
        idle(3);

        // literal pins on the model
        chk("pin_t3_mul", {29'h0, model_at(IR1, 0, 3)}, {29'h0, 16'h0040, 16'h0004, 3'b100});
        chk("pin_t4_mul", {29'h0, model_at(IR1, 0, 4)}, {29'h0, 16'h1002, 16'h0010, 3'b100});
        chk("pin_t6_mul", {29'h0, model_at(IR1, 0, 6)}, {29'h0, 16'h0014, 16'h0000, 3'b110});
        chk("pin_t4_div", {29'h0, model_at(IR2, 5, 9)}, {29'h0, 16'h1001, 16'h0020, 3'b100});
        chk("pin_len_div", 64'(model_len(IR2, 5)), 64'd12);
        chk("pin_illegal", {29'h0, model_at(IR3, 0, 3)}, {29'h0, 16'h0000, 16'h0000, 3'b101});

        // reset in the middle of T2
        begin_start(IR1);
        for (int c = 0; c < model_len(IR1, 0); c++) exp_q.push_back(model_at(IR1, 0, c));
        bus.start = 1'b0;
        bus.alu_done = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        chk("async_reset_outputs", {29'h0, act}, 64'h0);
        chk("async_reset_state", {61'h0, bus.state_dbg}, 64'h0);
        exp_q.delete();
        idle(2);
        reset = 1'b1;
        b0 = busy_cnt;
        idle(4);
        chk("idle_after_reset_busy", 64'(busy_cnt - b0), 64'd0);

        // MUL, alu_done already high in T4
        b0 = busy_cnt; d0 = done_cnt;
        begin_start(IR1);
        run_body(IR1, 0, 1'b0);
        idle(2);
        chk("mul_busy_cycles", 64'(busy_cnt - b0), 64'd7);
        chk("mul_done_count", 64'(done_cnt - d0), 64'd1);

        // DIV, alu_done low for 5 T4 cycles
        b0 = busy_cnt; d0 = done_cnt;
        begin_start(IR2);
        run_body(IR2, 5, 1'b0);
        idle(2);
        chk("div_busy_cycles", 64'(busy_cnt - b0), 64'd12);
        chk("div_done_count", 64'(done_cnt - d0), 64'd1);

        // undecodable opcode
        b0 = busy_cnt; d0 = done_cnt; i0 = ill_cnt; m0 = md_cnt;
        begin_start(IR3);
        run_body(IR3, 0, 1'b0);
        idle(3);
        chk("illegal_pulses", 64'(ill_cnt - i0), 64'd1);
        chk("illegal_no_done", 64'(done_cnt - d0), 64'd0);
        chk("illegal_no_muldiv", 64'(md_cnt - m0), 64'd0);
        chk("illegal_busy_cycles", 64'(busy_cnt - b0), 64'd4);

        // back-to-back instructions, start held through T6
        b0 = busy_cnt; d0 = done_cnt;
        begin_start(IR1);
        run_body(IR1, 0, 1'b1);
        run_body(IR2, 2, 1'b0);
        idle(2);
        chk("b2b_busy_cycles", 64'(busy_cnt - b0), 64'd16);
        chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);

        // register-index corners: Ra==Rb, Ra=15/Rb=0
        begin_start(mk_ir(OPM, 4'd7, 4'd7));
        run_body(mk_ir(OPM, 4'd7, 4'd7), 1, 1'b0);
        idle(1);
        begin_start(mk_ir(OPD, 4'd15, 4'd0));
        run_body(mk_ir(OPD, 4'd15, 4'd0), 3, 1'b0);
        idle(1);

        // alu_done rising exactly on the watchdog limit cycle
        d0 = done_cnt; i0 = ill_cnt;
        begin_start(IR1);
        run_body(IR1, MAXW - 1, 1'b0);
        idle(2);
        chk("limit_cycle_done", 64'(done_cnt - d0), 64'd1);
        chk("limit_cycle_no_illegal", 64'(ill_cnt - i0), 64'd0);

        // long ALU wait: aborts with the watchdog, otherwise keeps waiting
        d0 = done_cnt; i0 = ill_cnt;
        begin_start(IR2);
        run_body(IR2, 20, 1'b0);
        idle(3);
`ifdef MULDIV_WATCHDOG_EN
        chk("long_wait_illegal", 64'(ill_cnt - i0), 64'd1);
        chk("long_wait_done", 64'(done_cnt - d0), 64'd0);
`else
        chk("long_wait_illegal", 64'(ill_cnt - i0), 64'd0);
        chk("long_wait_done", 64'(done_cnt - d0), 64'd1);
`endif
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_control_seq.md
Name: muldiv_control_seq

Overview:
- Hardwired control sequencer that drives the register-transfer control inputs of the bus datapath (PCout, MARin, GPRout, MUL/DIV, LOin/HIin, ...) for the fetch of one instruction and its MUL/DIV execution.
- Sits directly upstream of the datapath and replaces hand-driven control strobes. It consumes the datapath's IR value and an ALU completion flag.
- Runs a fixed T0–T6 step sequence per instruction. Step T4 is stretched until the multi-cycle ALU reports done.

Parameters:
- BITS, 64, datapath word width (width of IRVal)
- REGISTERS, 16, number of GPRs (width of GPRout)
- OP_MUL, 5'b01110, opcode decoded as MUL
- OP_DIV, 5'b01111, opcode decoded as DIV
- MAX_WAIT, 64, T4 watchdog limit in cycles (used only with the optional feature)

Ports:
- Clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request to fetch and execute the next instruction
- IRVal  in  BITS  datapath IR contents
- alu_done  in  1  ALU result valid in RZ for the current MUL/DIV
- PCout, MARin, IncPC, RZin, Read, PCin, MDRin, IRin, MDRout, RYin, Zlowout, Zhighout, LOin, HIin, MUL, DIV  out  1 each  datapath controls
- GPRout  out  REGISTERS  one-hot GPR bus-drive select
- busy  out  1  high whenever state is not IDLE
- done  out  1  high during T6
- illegal  out  1  one-cycle pulse on undecodable opcode or watchdog abort

Behaviour:
- Fields:
  - opcode = IRVal[31:27]
  - Ra = IRVal[26:23]
  - Rb = IRVal[22:19]
  - bits above 31 are ignored.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. The state register is clocked on the rising edge.
- All outputs are decoded combinationally from the state register plus the IR fields. At reset and in IDLE every output is 0 and GPRout = 0.
- Reset: reset low forces IDLE immediately, from any state, including mid-T4. All outputs drop to 0 without waiting for a clock. A pending ALU operation is abandoned.
- IDLE: go to T0 on start=1, otherwise stay.
- T0: PCout, MARin, IncPC, RZin = 1. Next state T1.
- T1: Zlowout, PCin, Read, MDRin = 1. Next state T2.
- T2: MDRout, IRin = 1. IR is loaded at the end of T2. Next state T3.
- T3 (IR valid):
  - If opcode is OP_MUL or OP_DIV: GPRout[Ra] = 1, RYin = 1, next state T4.
  - Otherwise: all outputs 0, illegal = 1 for this cycle, next state IDLE.
- T4: GPRout[Rb] = 1, RZin = 1, MUL = (opcode==OP_MUL), DIV = (opcode==OP_DIV).
  - Stay in T4 while alu_done = 0.
  - Go to T5 on the first cycle with alu_done = 1.
  - Minimum T4 length is 1 cycle (alu_done already high).
- T5: Zlowout, LOin = 1. Next state T6.
- T6: Zhighout, HIin, done = 1.
  - Next state T0 if start = 1 (back-to-back, no IDLE bubble), else IDLE.
- start is sampled only in IDLE and T6 and ignored elsewhere. alu_done is ignored outside T4.
- Ra or Rb index >= REGISTERS: GPRout = 0 for that step, no error.
- Ra == Rb is legal; the same GPR is selected in T3 and T4.
- Exactly one GPRout bit is high in T3/T4; GPRout = 0 in all other states.
- Latency start→done: 7 cycles + (T4 cycles − 1).

Optional Feature:
- Macro: MULDIV_WATCHDOG_EN
- Defined:
  - A counter clears on T4 entry and increments each cycle spent in T4.
  - If it reaches MAX_WAIT with alu_done still 0: illegal = 1 for that cycle, all outputs 0 in that cycle, next state IDLE.
  - alu_done = 1 in the same cycle as the limit wins: proceed to T5.
  - The counter clears on reset.
- Not defined: no counter is synthesized and T4 waits indefinitely. MAX_WAIT is unused.

Test Plan:
- Reset low mid-T2, reset high, start=0 → all outputs 0, busy=0, state IDLE; no strobes until the next start.
- start=1 one cycle, IRVal=0x71200000, alu_done=1 throughout → strobe order:
  - T0..T2 per fetch
  - T3: GPRout=16'h0004, RYin
  - T4: GPRout=16'h0010, MUL=1, RZin
  - T5: LOin
  - T6: HIin, done
  - busy=1 for exactly 7 cycles.
- IRVal=0x79A80000, alu_done held low 5 cycles in T4 → T4 lasts 6 cycles with DIV=1, GPRout=16'h0020 throughout; done occurs 12 cycles after start.
- IRVal=0x4A920000 (opcode 9) → illegal pulses once in T3, MUL=DIV=0 throughout, return to IDLE, done never asserted.
- start held high across two instructions → T6 followed directly by T0, busy never drops between them.
- With MULDIV_WATCHDOG_EN defined and MAX_WAIT=8, alu_done=0 forever → illegal pulses at T4 cycle 8, then IDLE. Without the macro the sequencer stays in T4.
